// File: rtl/snes_ctrl_pkg.sv
// Shared types and constants for the SNES controller reader.
// Button bit positions, reserved-bit range and default timing live here.
package snes_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETTLE,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_DONE
  } state_t;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  localparam int RESERVED_MSB = 15;
  localparam int RESERVED_LSB = 12;

  localparam int DEF_HALF_CYC = 300;
  localparam int DEF_POLL_CYC = 833333;

  // An absent pad reads all-pressed because the board pulls the data line low.
  function automatic logic is_connected(input logic [15:0] raw);
    return raw[RESERVED_MSB:RESERVED_LSB] == '0;
  endfunction

  function automatic logic [15:0] btn_word(input logic [15:0] raw);
    return is_connected(raw) ? {4'b0000, raw[BTN_R:BTN_B]} : 16'h0000;
  endfunction

endpackage

// File: rtl/ctrl_sync2.sv
// Two-flop synchronizer for pad data; resets to the idle line level (1).
module ctrl_sync2 (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/snes_ctrl_reader.sv
// Polls two SNES pads over shared latch/clock lines and publishes button words.
// Optional SNES_CTRL_DEBOUNCE_EN: publish only when two consecutive polls agree.
module snes_ctrl_reader
  import snes_ctrl_pkg::*;
#(
  parameter int HALF_CYC = DEF_HALF_CYC,
  parameter int POLL_CYC = DEF_POLL_CYC
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrl_data1,
  input  logic        ctrl_data2,
  output logic        ctrl_latch,
  output logic        ctrl_clk,
  output logic [15:0] p1_buttons,
  output logic [15:0] p2_buttons,
  output logic        p1_connected,
  output logic        p2_connected,
  output logic        update,
  output logic        busy
);

  localparam int PW = $clog2(POLL_CYC);
  localparam int TW = $clog2(2 * HALF_CYC);
  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYC - 1);
  localparam logic [TW-1:0] LATCH_LAST = TW'(2 * HALF_CYC - 1);
  localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_CYC - 1);

  logic [PW-1:0] poll_cnt;
  logic          tick;
  logic          data1_s;
  logic          data2_s;
  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    bit_cnt;
  logic [15:0]   raw1;
  logic [15:0]   raw2;
`ifdef SNES_CTRL_DEBOUNCE_EN
  logic [15:0]   prev1;
  logic [15:0]   prev2;
`endif

  assign tick = (poll_cnt == POLL_LAST);

  ctrl_sync2 u_sync1 (.clock(clock), .reset_n(reset_n), .d(ctrl_data1), .q(data1_s));
  ctrl_sync2 u_sync2 (.clock(clock), .reset_n(reset_n), .d(ctrl_data2), .q(data2_s));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) poll_cnt <= '0;
    else          poll_cnt <= tick ? '0 : poll_cnt + 1'b1;
  end

  // Samples shift in from the top so the first bit read ends up in raw[0].
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      timer        <= '0;
      bit_cnt      <= '0;
      raw1         <= '0;
      raw2         <= '0;
      ctrl_latch   <= 1'b0;
      ctrl_clk     <= 1'b1;
      p1_buttons   <= '0;
      p2_buttons   <= '0;
      p1_connected <= 1'b0;
      p2_connected <= 1'b0;
      update       <= 1'b0;
      busy         <= 1'b0;
`ifdef SNES_CTRL_DEBOUNCE_EN
      prev1        <= '0;
      prev2        <= '0;
`endif
    end else begin
      update <= 1'b0;
      timer  <= timer + 1'b1;
      case (state)
        ST_IDLE: begin
          timer <= '0;
          if (tick) begin
            state      <= ST_LATCH;
            ctrl_latch <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_LATCH: begin
          if (timer == LATCH_LAST) begin
            timer      <= '0;
            ctrl_latch <= 1'b0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (timer == HALF_LAST) begin
            timer    <= '0;
            raw1     <= {~data1_s, raw1[15:1]};
            raw2     <= {~data2_s, raw2[15:1]};
            bit_cnt  <= '0;
            ctrl_clk <= 1'b0;
            state    <= ST_CLK_LO;
          end
        end
        ST_CLK_LO: begin
          if (timer == HALF_LAST) begin
            timer    <= '0;
            ctrl_clk <= 1'b1;
            state    <= ST_CLK_HI;
          end
        end
        ST_CLK_HI: begin
          if (timer == HALF_LAST) begin
            timer <= '0;
            if (bit_cnt == 4'd15) begin
              state <= ST_DONE;
            end else begin
              raw1     <= {~data1_s, raw1[15:1]};
              raw2     <= {~data2_s, raw2[15:1]};
              bit_cnt  <= bit_cnt + 1'b1;
              ctrl_clk <= 1'b0;
              state    <= ST_CLK_LO;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          update <= 1'b1;
`ifdef SNES_CTRL_DEBOUNCE_EN
          if (raw1 == prev1) begin
            p1_buttons   <= btn_word(raw1);
            p1_connected <= is_connected(raw1);
          end
          if (raw2 == prev2) begin
            p2_buttons   <= btn_word(raw2);
            p2_connected <= is_connected(raw2);
          end
          prev1 <= raw1;
          prev2 <= raw2;
`else
          p1_buttons   <= btn_word(raw1);
          p1_connected <= is_connected(raw1);
          p2_buttons   <= btn_word(raw2);
          p2_connected <= is_connected(raw2);
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
